vga_fb_writer: RTL and testbench
================================

VGA_FB_WRITER -- requirements
Module: vga_fb_writer

Interface
REQ-001 SHALL have parameter WORDS, default 75, meaning the framebuffer depth in 32-bit words (300 one-byte cells = 20x15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port wr_valid, input, 1 bit: CPU write request.
REQ-005 SHALL have port wr_ready, output, 1 bit: the block accepts a write this cycle.
REQ-006 SHALL have port wr_addr, input, 9 bits: cell byte address; word index = wr_addr[8:2], and wr_addr[1:0] is ignored.
REQ-007 SHALL have port wr_data, input, 32 bits: write data; byte offset 0 is wr_data[31:24], offset 3 is wr_data[7:0].
REQ-008 SHALL have port wr_be, input, 4 bits: byte enables; wr_be[3] enables [31:24] and wr_be[0] enables [7:0].
REQ-009 SHALL have port clear_req, input, 1 bit: request to fill the whole framebuffer.
REQ-010 SHALL have port clear_color, input, 8 bits: fill byte (2-bit R,G,B in bits [5:0]).
REQ-011 SHALL have port busy, output, 1 bit: a clear is in progress.
REQ-012 SHALL have port oob, output, 1 bit: sticky flag, set when a write to an out-of-range address is accepted.
REQ-013 SHALL have port vaddr, input, 9 bits: display-side cell address; word index = vaddr[8:2].
REQ-014 SHALL have port vdata, output, 32 bits: display-side word.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-016 SHALL drive wr_ready = 1 in IDLE and 0 in CLEAR.
REQ-017 SHALL accept a write on any cycle where wr_valid && wr_ready.
REQ-018 On an accepted write with word index < WORDS, SHALL update only the enabled bytes on that clock edge; wr_be = 0000 SHALL leave memory unchanged.
REQ-019 On an accepted write with word index >= WORDS, SHALL leave memory unchanged and set oob on the next edge.
REQ-020 In IDLE, clear_req = 1 SHALL latch clear_color, zero the clear index, and enter CLEAR on the next edge.
REQ-021 If clear_req and an accepted write occur in the same IDLE cycle, SHALL perform the write that cycle, then run the full clear, so the final content is clear_color.
REQ-022 In CLEAR, SHALL write {c,c,c,c} (c = latched color) to word index i each cycle, for i = 0..WORDS-1.
REQ-023 After the write of index WORDS-1, SHALL return to IDLE; CLEAR lasts exactly WORDS cycles.
REQ-024 SHALL hold busy = 1 exactly while in CLEAR.
REQ-025 SHALL ignore clear_req while in CLEAR, with no restart and no queuing.
REQ-026 SHALL ignore changes to clear_color during CLEAR.
REQ-027 SHALL register vdata with 1-cycle latency: vdata(t+1) = mem[vaddr(t)[8:2]].
REQ-028 SHALL return 0 on vdata when vaddr[8:2] >= WORDS.
REQ-029 SHALL provide read-before-write behaviour: a read of a word being written in the same cycle returns the old word.
REQ-030 SHALL keep the display read port independent of FSM state; display reads are never stalled.
REQ-031 SHALL size the memory to WORDS x 32 bits with one write port and one read port, mappable to a single block RAM.

Reset
REQ-032 While reset = 1, SHALL hold state = IDLE, busy = 0, oob = 0, vdata = 0 and clear index = 0, independent of clk.
REQ-033 SHALL not initialise memory contents on reset.
REQ-034 Reset asserted mid-CLEAR SHALL abort the clear immediately, leaving already-written words filled and the remaining words unchanged.
REQ-035 After reset deasserts, wr_ready SHALL be 1.

Verification
REQ-036 Byte write: write 0x11223344 to wr_addr 8 with wr_be 1111, then write 0xAA000000 to wr_addr 8 with wr_be 1000 -> one cycle after vaddr = 9, vdata = 0xAA223344.
REQ-037 Clear: clear_req = 1 with clear_color 0x15 -> busy high for exactly 75 cycles and wr_ready low for the same cycles; afterwards vaddr 0, 148 and 296 each read 0x15151515.
REQ-038 Collision: in IDLE, same cycle, write 0xFFFFFFFF to word 3 and clear_req with color 0x00 -> after busy falls, word 3 reads 0x00000000.
REQ-039 Out-of-range: accepted write to wr_addr 300 -> oob = 1 next cycle, all words unchanged; vaddr 300 -> vdata = 0.
REQ-040 Reset mid-clear: assert reset 10 cycles into CLEAR, with color 0x3F over prior content 0 -> busy = 0 and vdata = 0 immediately; words 0..9 read 0x3F3F3F3F and words 10..74 read 0.
REQ-041 Read-during-write: vaddr = 4 while writing 0x12345678 to word 1 -> vdata shows the old value next cycle and 0x12345678 the cycle after.

Source files
------------

// File: rtl/vga_fb_writer.sv
// Character-cell framebuffer: CPU byte-enabled writes, hardware fill (clear), and a
// registered display read port with read-before-write behaviour on the shared word.
module vga_fb_writer #(
  parameter int WORDS = 75
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [8:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  input  logic        clear_req,
  input  logic [7:0]  clear_color,
  output logic        busy,
  output logic        oob,
  input  logic [8:0]  vaddr,
  output logic [31:0] vdata
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [7:0] WORDS8   = 8'(WORDS);
  localparam logic [6:0] LAST_IDX = 7'(WORDS - 1);

  state_t      state;
  logic [6:0]  clr_idx;
  logic [7:0]  clr_color;

  logic [31:0] mem [WORDS];

  logic [6:0]  w_idx;
  logic [6:0]  r_idx;
  logic        w_in_range;
  logic        r_in_range;
  logic        wr_accept;

  logic        mem_we;
  logic [6:0]  mem_idx;
  logic [31:0] mem_wdat;
  logic [3:0]  mem_be;

  // Byte-offset bits only select a cell inside a word and play no part in addressing.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[1:0], vaddr[1:0]};

  assign w_idx      = wr_addr[8:2];
  assign r_idx      = vaddr[8:2];
  assign w_in_range = ({1'b0, w_idx} < WORDS8);
  assign r_in_range = ({1'b0, r_idx} < WORDS8);

  assign wr_ready   = (state == IDLE);
  assign busy       = (state == CLEAR);
  assign wr_accept  = wr_valid && wr_ready;

  // Single write port: the fill owns it during CLEAR, the CPU otherwise.
  always_comb begin
    mem_we   = 1'b0;
    mem_idx  = w_idx;
    mem_wdat = wr_data;
    mem_be   = wr_be;
    if (state == CLEAR) begin
      mem_we   = 1'b1;
      mem_idx  = clr_idx;
      mem_wdat = {4{clr_color}};
      mem_be   = 4'hF;
    end else if (wr_accept && w_in_range) begin
      mem_we   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vdata <= '0;
    end else begin
      vdata <= r_in_range ? mem[r_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clr_idx   <= '0;
      clr_color <= '0;
      oob       <= 1'b0;
    end else begin
      if (wr_accept && !w_in_range) oob <= 1'b1;
      case (state)
        IDLE: begin
          if (clear_req) begin
            clr_color <= clear_color;
            clr_idx   <= '0;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            clr_idx <= '0;
            state   <= IDLE;
          end else begin
            clr_idx <= clr_idx + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: reset, byte writes, clear, collision, out-of-range,
// read-during-write and reset during a clear, with a small word model for expectations.
module tb_vga_fb_writer;

  localparam int WORDS = 75;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        busy;
  logic        oob;
  logic [8:0]  vaddr;
  logic [31:0] vdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_mem [WORDS];

  vga_fb_writer #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .clear_req(clear_req),
    .clear_color(clear_color), .busy(busy), .oob(oob), .vaddr(vaddr), .vdata(vdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_valid = 1'b0; wr_be = 4'h0;
  endtask

  task automatic read_word(input int idx, output logic [31:0] d);
    vaddr = 9'(idx * 4);
    tick();
    d = vdata;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", name, busy, n);
    end
  endtask

  task automatic check_all_words(input string name);
    logic [31:0] d;
    for (int i = 0; i < WORDS; i++) begin
      read_word(i, d);
      checks++;
      if (d !== exp_mem[i]) begin
        errors++; $display("FAIL %s word %0d: got %h want %h", name, i, d, exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    clear_req = 1'b0; clear_color = '0; vaddr = '0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (oob !== 1'b0) begin errors++; $display("FAIL rst_oob: got %b want 0", oob); end
    checks++; if (vdata !== 32'h0) begin errors++; $display("FAIL rst_vdata: got %h want 0", vdata); end
    reset = 1'b0;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", wr_ready); end
  endtask

  // Fill with 0x15; a second clear_req and a colour change mid-clear must be ignored.
  task automatic test_clear;
    int busy_cnt = 0;
    int nrdy_cnt = 0;
    logic [31:0] d;
    clear_req = 1'b1; clear_color = 8'h15;
    tick();
    clear_req = 1'b0;
    for (int n = 0; n < 200 && busy === 1'b1; n++) begin
      busy_cnt++;
      if (wr_ready === 1'b0) nrdy_cnt++;
      if (n == 5) begin clear_req = 1'b1; clear_color = 8'h2A; end
      if (n == 6) clear_req = 1'b0;
      tick();
    end
    checks++; if (busy_cnt != 75) begin errors++; $display("FAIL clr_busy_len: got %0d want 75", busy_cnt); end
    checks++; if (nrdy_cnt != 75) begin errors++; $display("FAIL clr_nrdy_len: got %0d want 75", nrdy_cnt); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_no_restart: busy=%b want 0", busy); end
    for (int i = 0; i < WORDS; i++) exp_mem[i] = 32'h15151515;
    vaddr = 9'd0;   tick(); d = vdata;
    checks++; if (d !== 32'h15151515) begin errors++; $display("FAIL clr_v0: got %h want 15151515", d); end
    vaddr = 9'd148; tick(); d = vdata;
    checks++; if (d !== 32'h15151515) begin errors++; $display("FAIL clr_v148: got %h want 15151515", d); end
    vaddr = 9'd296; tick(); d = vdata;
    checks++; if (d !== 32'h15151515) begin errors++; $display("FAIL clr_v296: got %h want 15151515", d); end
  endtask

  task automatic test_byte_write;
    logic [31:0] d;
    cpu_write(9'd8, 32'h11223344, 4'b1111);
    cpu_write(9'd8, 32'hAA000000, 4'b1000);
    vaddr = 9'd9; tick(); d = vdata;
    checks++; if (d !== 32'hAA223344) begin errors++; $display("FAIL bw_msb: got %h want aa223344", d); end
    cpu_write(9'd10, 32'hDEADBEEF, 4'b0000);
    read_word(2, d);
    checks++; if (d !== 32'hAA223344) begin errors++; $display("FAIL bw_be0: got %h want aa223344", d); end
    cpu_write(9'd11, 32'h00BBCC00, 4'b0110);
    read_word(2, d);
    checks++; if (d !== 32'hAABBCC44) begin errors++; $display("FAIL bw_mid: got %h want aabbcc44", d); end
    cpu_write(9'd8, 32'h000000EE, 4'b0001);
    read_word(2, d);
    checks++; if (d !== 32'hAABBCCEE) begin errors++; $display("FAIL bw_lsb: got %h want aabbccee", d); end
    exp_mem[2] = 32'hAABBCCEE;
  endtask

  task automatic test_read_during_write;
    vaddr = 9'd4;
    wr_valid = 1'b1; wr_addr = 9'd4; wr_data = 32'h12345678; wr_be = 4'hF;
    tick();
    wr_valid = 1'b0; wr_be = 4'h0;
    checks++; if (vdata !== 32'h15151515) begin errors++; $display("FAIL rdw_old: got %h want 15151515", vdata); end
    tick();
    checks++; if (vdata !== 32'h12345678) begin errors++; $display("FAIL rdw_new: got %h want 12345678", vdata); end
    exp_mem[1] = 32'h12345678;
  endtask

  task automatic test_oob;
    logic [31:0] d;
    checks++; if (oob !== 1'b0) begin errors++; $display("FAIL oob_pre: got %b want 0", oob); end
    cpu_write(9'd300, 32'hFFFFFFFF, 4'b1111);
    checks++; if (oob !== 1'b1) begin errors++; $display("FAIL oob_set: got %b want 1", oob); end
    cpu_write(9'd511, 32'hFFFFFFFF, 4'b1111);
    vaddr = 9'd300; tick(); d = vdata;
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oob_read300: got %h want 0", d); end
    vaddr = 9'd508; tick(); d = vdata;
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oob_read508: got %h want 0", d); end
    check_all_words("oob_unchanged");
    cpu_write(9'd20, 32'h01020304, 4'b1111);
    exp_mem[5] = 32'h01020304;
    checks++; if (oob !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", oob); end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    wr_valid = 1'b1; wr_addr = 9'd12; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    clear_req = 1'b1; clear_color = 8'h00;
    tick();
    wr_valid = 1'b0; wr_be = 4'h0; clear_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL col_busy: got %b want 1", busy); end
    wait_idle("col");
    for (int i = 0; i < WORDS; i++) exp_mem[i] = 32'h0;
    read_word(3, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL col_word3: got %h want 0", d); end
    check_all_words("col_all");
  endtask

  task automatic test_reset_mid_clear;
    clear_req = 1'b1; clear_color = 8'h3F; vaddr = 9'd0;
    tick();
    clear_req = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    checks++; if (vdata !== 32'h3F3F3F3F) begin errors++; $display("FAIL rmc_pre_vdata: got %h want 3f3f3f3f", vdata); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy: got %b want 0", busy); end
    checks++; if (vdata !== 32'h0) begin errors++; $display("FAIL rmc_vdata: got %h want 0", vdata); end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmc_ready: got %b want 1", wr_ready); end
    checks++; if (oob !== 1'b0) begin errors++; $display("FAIL rmc_oob: got %b want 0", oob); end
    for (int i = 0; i < 10; i++) exp_mem[i] = 32'h3F3F3F3F;
    check_all_words("rmc");
  endtask

  initial begin
    test_reset();
    test_clear();
    test_byte_write();
    test_read_during_write();
    test_oob();
    test_collision();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
